cpu_seq_ctrl: RTL
=================

# cpu_seq_ctrl

Multicycle sequencer for the MIPS CPU core. It steps each instruction through FETCH, EXEC1 and EXEC2, and drives `active`, the one-cycle `fetch` advance strobe to the program counter, and instruction-register load. It also drives memory read/write requests, with Avalon-style `waitrequest` stalling and a bus-timeout watchdog. It halts the core when the PC reaches the halt address.

## Interface
- `HALT_ADDR`, default 32'h0000_0000: PC value that stops the core.
- `MAX_WAIT`, default 16: maximum consecutive stalled cycles tolerated. 0 disables the timeout. Legal range 0..65535.

- `clk` in 1: the single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high; forces every register to its reset value immediately.
- `pc_value` in 32: current PC from the program counter.
- `is_load` in 1: decoded instruction needs a data read.
- `is_store` in 1: decoded instruction needs a data write.
- `waitrequest` in 1: memory stall; the current request is held while high.
- `active` out 1: core running (FETCH, EXEC1 or EXEC2).
- `fetch` out 1: one-cycle PC advance strobe.
- `ir_load` out 1: capture readdata into the instruction register.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `state` out 3: IDLE=0, FETCH=1, EXEC1=2, EXEC2=3, HALTED=4.
- `err` out 1: sticky bus-timeout flag.
- `instr_count` out 32: retired-instruction counter.

## Operation
- Reset values: `state`=IDLE, `active`=0, `fetch`=0, `ir_load`=0, `mem_read`=0, `mem_write`=0, `err`=0, `instr_count`=0, internal `wait_cnt`=0.
- **IDLE**: always goes to FETCH on the next edge. All strobes are 0.
- **FETCH**:
  - If `pc_value`==`HALT_ADDR`: no request is issued and the next state is HALTED.
  - Otherwise `mem_read`=1. The state is held while `waitrequest`=1.
  - In the cycle `waitrequest`=0: `ir_load`=1 for that cycle only, and the next state is EXEC1.
- **EXEC1**:
  - If `is_load`: `mem_read`=1.
  - Else if `is_store`: `mem_write`=1.
  - `is_load` and `is_store` both high is treated as a load.
  - With a request outstanding, the state is held while `waitrequest`=1 and moves to EXEC2 when it is 0.
  - With no request, the state moves to EXEC2 on the next edge.
- **EXEC2**: `fetch`=1 for exactly this cycle, `instr_count` increments (wraps at 2^32-1 → 0), and the next state is FETCH.
- **HALTED**: terminal until reset. All strobes are 0, and `instr_count` and `err` are frozen.
- **Strobe decode**: `mem_read`, `mem_write`, `ir_load` and `fetch` are combinational from `state` and inputs only; they never depend on data returned the same cycle.
- `active`=1 exactly when `state` is FETCH, EXEC1 or EXEC2.
- **Watchdog**:
  - `wait_cnt` (16 bit) increments on every cycle with a request asserted and `waitrequest`=1.
  - It clears on any cycle where a request completes or no request is asserted.
  - If `MAX_WAIT`≠0 and a stalled cycle would bring `wait_cnt` to `MAX_WAIT`, the next state is HALTED and `err`←1. The request drops on entering HALTED.
- `waitrequest` is ignored in IDLE, EXEC2, HALTED, and in EXEC1 with no request.

## Timing
- Instruction latency with zero wait states:
  - 3 cycles for a non-memory instruction (FETCH, EXEC1, EXEC2).
  - 3 cycles for a load/store, since the data access completes in EXEC1.
  - Each stalled cycle adds 1.
- `fetch` is asserted exactly once per retired instruction. The PC sees the new value on the edge ending EXEC2, so `pc_value` is valid on entering FETCH.
- The halt check uses `pc_value` during the FETCH cycle. The halt-address fetch is never issued to memory and is not counted.
- Reset asserted mid-request drops `mem_read`/`mem_write` asynchronously in the same cycle. On deassertion the sequence restarts from IDLE.
- After reset: first FETCH at cycle 1; first `ir_load` at cycle 1 at the earliest.

## Test plan
- Reset, `pc_value`=32'hBFC0_0000, `waitrequest`=0, non-memory instructions: `state` sequence 0,1,2,3,1,2,3…; `fetch` pulses every 3rd cycle; `instr_count`=2 after 7 cycles.
- FETCH with `waitrequest` high for 3 cycles: `mem_read` stays 1 for 4 cycles; `ir_load`=1 only in the 4th; `err`=0.
- Load in EXEC1 with 2 stall cycles, then a store with 0 stalls: `mem_read` high 3 cycles in EXEC1, then `mem_write` high 1 cycle; `mem_read` and `mem_write` are never both high.
- `pc_value`=0 entering FETCH: no `mem_read`; `state`=4 next cycle; `active`=0; `instr_count` frozen thereafter.
- `MAX_WAIT`=4, `waitrequest` stuck at 1 in FETCH: HALTED after the 4th stalled cycle; `err`=1; `mem_read`=0 from then on.
- Assert `reset` during an EXEC1 store stall: `mem_write` falls in the same cycle without a clock edge; all outputs return to reset values; after release, IDLE→FETCH resumes.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multicycle FETCH/EXEC1/EXEC2 sequencer for the MIPS core,
// issuing Avalon-style memory requests with waitrequest stalls, a bus
// timeout watchdog, and a halt when the PC reaches HALT_ADDR.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   pc_value[31:0]         current PC (halt check in FETCH)
//   is_load, is_store      decoded memory access type (load wins if both)
//   waitrequest            memory stall, holds the current request
//   active                 core in FETCH, EXEC1 or EXEC2
//   fetch                  one-cycle PC advance strobe (EXEC2)
//   ir_load                capture readdata into the instruction register
//   mem_read, mem_write    memory requests
//   state[2:0]             IDLE=0 FETCH=1 EXEC1=2 EXEC2=3 HALTED=4
//   err                    sticky bus-timeout flag
//   instr_count[31:0]      retired-instruction counter
module cpu_seq_ctrl #(
    parameter logic [31:0] HALT_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WAIT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_value,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        waitrequest,
    output logic        active,
    output logic        fetch,
    output logic        ir_load,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  state,
    output logic        err,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC1  = 3'd2,
        S_EXEC2  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    // The timeout fires on the stalled cycle that would make the count
    // reach MAX_WAIT, i.e. when the current count equals MAX_WAIT-1.
    localparam bit          LP_WD_EN = (MAX_WAIT != 0);
    localparam logic [15:0] LP_LAST  = LP_WD_EN ? 16'(MAX_WAIT - 1) : 16'd0;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_wait_cnt;
    logic        r_err;
    logic [31:0] r_instr_count;

    logic        w_halt;
    logic        w_rd;
    logic        w_wr;
    logic        w_req;
    logic        w_stall;
    logic        w_timeout;
    logic        w_ir_load;
    logic        w_fetch;

    assign w_halt = (pc_value == HALT_ADDR);

    // Request decode: depends on state and decoded inputs only.
    always_comb begin
        w_rd = 1'b0;
        w_wr = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                if (!w_halt) w_rd = 1'b1;
            end
            S_EXEC1: begin
                if (is_load)       w_rd = 1'b1;
                else if (is_store) w_wr = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_req     = w_rd | w_wr;
    assign w_stall   = w_req & waitrequest;
    assign w_timeout = LP_WD_EN && w_stall && (r_wait_cnt == LP_LAST);

    always_comb begin
        w_next    = r_state;
        w_ir_load = 1'b0;
        w_fetch   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                if (w_halt) begin
                    w_next = S_HALTED;
                end else if (waitrequest) begin
                    if (w_timeout) w_next = S_HALTED;
                end else begin
                    w_ir_load = 1'b1;
                    w_next    = S_EXEC1;
                end
            end
            S_EXEC1: begin
                if (w_stall) begin
                    if (w_timeout) w_next = S_HALTED;
                end else begin
                    w_next = S_EXEC2;
                end
            end
            S_EXEC2: begin
                w_fetch = 1'b1;
                w_next  = S_FETCH;
            end
            S_HALTED: begin
                w_next = S_HALTED;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= 16'd0;
            r_err         <= 1'b0;
            r_instr_count <= 32'd0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_stall ? (r_wait_cnt + 16'd1) : 16'd0;
            if (w_timeout) r_err <= 1'b1;
            if (w_fetch)   r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign mem_read    = w_rd;
    assign mem_write   = w_wr;
    assign ir_load     = w_ir_load;
    assign fetch       = w_fetch;
    assign state       = r_state;
    assign err         = r_err;
    assign instr_count = r_instr_count;
    assign active      = (r_state == S_FETCH) ||
                         (r_state == S_EXEC1) ||
                         (r_state == S_EXEC2);

endmodule
